// File: rtl/ann_stream_sequencer.sv
// Turns a start pulse plus a valid/ready word stream into registered ANN datapath strobes; strobes land one cycle after their accept.
// Backpressure: s_ready is high only in the input/bias/weight accept states; stalls hold all state and counters.
module ann_stream_sequencer #(
    parameter int N_IN     = 32,
    parameter int N_NEURON = 10,
    parameter int DW       = 16,
    parameter int MAX_LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] in_o,
    output logic          ld_in_o,
    output logic          ld_weight_o,
    output logic          shift_in_o,
    output logic          ld_multiplication_o,
    output logic          ld_bias_LSB_o,
    output logic          ld_bias_MSB_o,
    output logic          bias_addition_o,
    output logic          ReLU_computation_o,
    output logic          ld_max_func_o,
    output logic          rst_sum_o,
    output logic [3:0]    ld_neuron_o,
    input  logic [3:0]    number_i,
    output logic          busy,
    output logic          done,
    output logic [3:0]    result
);

    localparam int WCW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int LCW = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_IN, S_CLR, S_BIAS_L, S_BIAS_H, S_W_ACC,
        S_W_SHIFT, S_B_ADD, S_RELU, S_MAX, S_WAIT, S_DONE
    } state_t;

    typedef struct packed {
        logic ld_in;
        logic ld_weight;
        logic shift_in;
        logic ld_mult;
        logic ld_bias_lsb;
        logic ld_bias_msb;
        logic bias_add;
        logic relu;
        logic ld_max;
        logic rst_sum;
    } strobe_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  word_cnt_q, word_cnt_d;
    logic [3:0]      neuron_cnt_q, neuron_cnt_d;
    logic [LCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DW-1:0]   in_q, in_d;
    strobe_t         stb_q, stb_d;
    logic [3:0]      ld_neuron_q, ld_neuron_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [3:0]      result_q, result_d;
    logic            accept;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        neuron_cnt_d = neuron_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        in_d         = in_q;
        stb_d        = '0;
        ld_neuron_d  = ld_neuron_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        result_d     = result_q;

        s_ready = (state_q == S_LOAD_IN) || (state_q == S_BIAS_L) ||
                  (state_q == S_BIAS_H)  || (state_q == S_W_ACC);
        accept  = s_ready && s_valid;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD_IN;
                    busy_d       = 1'b1;
                    word_cnt_d   = '0;
                    neuron_cnt_d = '0;
                end
            end
            S_LOAD_IN: begin
                if (accept) begin
                    stb_d.ld_in = 1'b1;
                    in_d        = s_data;
                    if (word_cnt_q == WCW'(N_IN - 1)) begin
                        word_cnt_d = '0;
                        state_d    = S_CLR;
                    end else begin
                        word_cnt_d = word_cnt_q + WCW'(1);
                    end
                end
            end
            S_CLR: begin
                stb_d.rst_sum = 1'b1;
                ld_neuron_d   = neuron_cnt_q;
                state_d       = S_BIAS_L;
            end
            S_BIAS_L: begin
                if (accept) begin
                    stb_d.ld_bias_lsb = 1'b1;
                    in_d              = s_data;
                    state_d           = S_BIAS_H;
                end
            end
            S_BIAS_H: begin
                if (accept) begin
                    stb_d.ld_bias_msb = 1'b1;
                    in_d              = s_data;
                    word_cnt_d        = '0;
                    state_d           = S_W_ACC;
                end
            end
            S_W_ACC: begin
                if (accept) begin
                    stb_d.ld_weight = 1'b1;
                    // The multiplier is armed together with the first weight of each neuron.
                    stb_d.ld_mult   = (word_cnt_q == '0);
                    in_d            = s_data;
                    state_d         = (word_cnt_q < WCW'(N_IN - 1)) ? S_W_SHIFT : S_B_ADD;
                end
            end
            S_W_SHIFT: begin
                stb_d.shift_in = 1'b1;
                word_cnt_d     = word_cnt_q + WCW'(1);
                state_d        = S_W_ACC;
            end
            S_B_ADD: begin
                stb_d.bias_add = 1'b1;
                state_d        = S_RELU;
            end
            S_RELU: begin
                stb_d.relu  = 1'b1;
                ld_neuron_d = neuron_cnt_q;
                if (neuron_cnt_q == 4'(N_NEURON - 1)) begin
                    state_d = S_MAX;
                end else begin
                    neuron_cnt_d = neuron_cnt_q + 4'd1;
                    state_d      = S_CLR;
                end
            end
            S_MAX: begin
                stb_d.ld_max = 1'b1;
                wait_cnt_d   = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // First WAIT cycle is the one where ld_max_func_o is visible.
                if (wait_cnt_q == LCW'(MAX_LAT)) begin
                    result_d = number_i;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + LCW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_cnt_q   <= '0;
            neuron_cnt_q <= '0;
            wait_cnt_q   <= '0;
            in_q         <= '0;
            stb_q        <= '0;
            ld_neuron_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            neuron_cnt_q <= neuron_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            in_q         <= in_d;
            stb_q        <= stb_d;
            ld_neuron_q  <= ld_neuron_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

    assign in_o                = in_q;
    assign ld_in_o             = stb_q.ld_in;
    assign ld_weight_o         = stb_q.ld_weight;
    assign shift_in_o          = stb_q.shift_in;
    assign ld_multiplication_o = stb_q.ld_mult;
    assign ld_bias_LSB_o       = stb_q.ld_bias_lsb;
    assign ld_bias_MSB_o       = stb_q.ld_bias_msb;
    assign bias_addition_o     = stb_q.bias_add;
    assign ReLU_computation_o  = stb_q.relu;
    assign ld_max_func_o       = stb_q.ld_max;
    assign rst_sum_o           = stb_q.rst_sum;
    assign ld_neuron_o         = ld_neuron_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign result              = result_q;

endmodule

// File: tb/tb_ann_stream_sequencer.sv
// Bench for ann_stream_sequencer: random job data and stalls checked against an expected strobe-event list built from the job layout.
module tb_ann_stream_sequencer;

    localparam int N_IN     = 32;
    localparam int N_NEURON = 10;
    localparam int DW       = 16;
    localparam int MAX_LAT  = 1;
    localparam int TOTAL    = N_IN + N_NEURON * (N_IN + 2);

    // Event mask bit positions
    localparam int B_IN = 9, B_W = 8, B_SH = 7, B_MUL = 6, B_BL = 5, B_BH = 4,
                   B_BA = 3, B_RELU = 2, B_MAX = 1, B_RST = 0;

    logic          clk, rst, start, s_valid, s_ready;
    logic [DW-1:0] s_data, in_o;
    logic          ld_in_o, ld_weight_o, shift_in_o, ld_multiplication_o;
    logic          ld_bias_LSB_o, ld_bias_MSB_o, bias_addition_o;
    logic          ReLU_computation_o, ld_max_func_o, rst_sum_o;
    logic [3:0]    ld_neuron_o, number_i, result;
    logic          busy, done;

    ann_stream_sequencer #(
        .N_IN(N_IN), .N_NEURON(N_NEURON), .DW(DW), .MAX_LAT(MAX_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .in_o(in_o), .ld_in_o(ld_in_o), .ld_weight_o(ld_weight_o),
        .shift_in_o(shift_in_o), .ld_multiplication_o(ld_multiplication_o),
        .ld_bias_LSB_o(ld_bias_LSB_o), .ld_bias_MSB_o(ld_bias_MSB_o),
        .bias_addition_o(bias_addition_o), .ReLU_computation_o(ReLU_computation_o),
        .ld_max_func_o(ld_max_func_o), .rst_sum_o(rst_sum_o),
        .ld_neuron_o(ld_neuron_o), .number_i(number_i),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            tests, fails;
    logic [DW-1:0] words [TOTAL];
    logic [29:0]   exp_q [$];
    int            exp_idx;
    int            cnt [10];
    int            done_cnt;
    logic [3:0]    exp_digit;
    bit            mon_on;
    bit            pend;
    logic [DW-1:0] pend_word;
    bit            max_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] strobe_mask();
        return {ld_in_o, ld_weight_o, shift_in_o, ld_multiplication_o, ld_bias_LSB_o,
                ld_bias_MSB_o, bias_addition_o, ReLU_computation_o, ld_max_func_o, rst_sum_o};
    endfunction

    function automatic void push(input int bitpos, input int bit2, input logic [DW-1:0] d,
                                 input logic [3:0] n);
        logic [9:0] m;
        m = '0;
        m[bitpos] = 1'b1;
        if (bit2 >= 0) m[bit2] = 1'b1;
        exp_q.push_back({m, d, n});
    endfunction

    // Expected job: inputs, then per neuron clear, two bias halves, weights with shifts in between, add, ReLU; then max.
    task automatic build_job();
        int base;
        exp_q.delete();
        exp_idx  = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) cnt[i] = 0;
        for (int i = 0; i < TOTAL; i++) words[i] = DW'($urandom);
        for (int i = 0; i < N_IN; i++) push(B_IN, -1, words[i], 4'd0);
        for (int n = 0; n < N_NEURON; n++) begin
            base = N_IN + n * (N_IN + 2);
            push(B_RST, -1, '0, 4'(n));
            push(B_BL, -1, words[base], 4'd0);
            push(B_BH, -1, words[base + 1], 4'd0);
            for (int k = 0; k < N_IN; k++) begin
                push(B_W, (k == 0) ? B_MUL : -1, words[base + 2 + k], 4'd0);
                if (k < N_IN - 1) push(B_SH, -1, '0, 4'd0);
            end
            push(B_BA, -1, '0, 4'd0);
            push(B_RELU, -1, '0, 4'(n));
        end
        push(B_MAX, -1, '0, 4'd0);
    endtask

    always @(negedge clk) begin
        logic [9:0]    m;
        logic          ds;
        logic [29:0]   ev;
        if (mon_on) begin
            m  = strobe_mask();
            ds = ld_in_o | ld_weight_o | ld_bias_LSB_o | ld_bias_MSB_o;
            if (pend || ds)
                check("accept_to_strobe", {ds, ds ? in_o : 16'h0}, {pend, pend ? pend_word : 16'h0});
            pend      = s_valid && s_ready;
            pend_word = s_data;
            if (m != '0) begin
                for (int i = 0; i < 10; i++) cnt[i] += int'(m[i]);
                ev = {m, ds ? in_o : 16'h0, (m[B_RST] | m[B_RELU]) ? ld_neuron_o : 4'h0};
                if (exp_idx < exp_q.size()) begin
                    check("strobe_seq", ev, exp_q[exp_idx]);
                    exp_idx++;
                end else begin
                    check("extra_strobe", ev, 30'h0);
                end
            end
            if (ld_max_func_o) max_seen = 1'b1;
            if (done) begin
                done_cnt++;
                check("done_result", {busy, result}, {1'b0, exp_digit});
            end
        end
    end

    // Datapath model: the digit is valid only MAX_LAT cycle(s) after ld_max_func_o, garbage otherwise.
    always @(posedge clk) begin
        #1;
        if (max_seen) begin
            number_i = exp_digit;
            max_seen = 1'b0;
        end else begin
            number_i = ~exp_digit;
        end
    end

    task automatic run_job(input bit stall, input int start_at, input int abort_at);
        int  idx, guard;
        bit  acc, aborted;
        int  exp_cnt [10];
        build_job();
        @(posedge clk); #1;
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = words[0];
        @(negedge clk);
        check("idle_not_ready", {s_ready, busy}, 2'b00);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_set", busy, 1'b1);
        idx = 0; guard = 0; aborted = 1'b0;
        while (idx < TOTAL && guard < 6000) begin
            s_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_data  = s_valid ? words[idx] : DW'($urandom);
            start   = (idx == start_at);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                if (idx == abort_at) begin
                    aborted = 1'b1;
                    break;
                end
                idx++;
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("abort_outputs", {strobe_mask(), s_ready, busy, done, result}, 64'h0);
            repeat (10) @(posedge clk);
            #1;
            check("abort_stays_idle", {strobe_mask(), busy, done_cnt[0]}, 64'h0);
            return;
        end
        check("all_words_accepted", idx, TOTAL);
        guard = 0;
        while (done_cnt == 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("events_seen", exp_idx, exp_q.size());
        check("busy_after_done", {busy, done}, 2'b00);
        exp_cnt = '{N_IN, N_NEURON * N_IN, N_NEURON * (N_IN - 1), N_NEURON, N_NEURON,
                    N_NEURON, N_NEURON, N_NEURON, 1, N_NEURON};
        for (int i = 0; i < 10; i++)
            check($sformatf("strobe_count[%0d]", 9 - i), cnt[9 - i], exp_cnt[i]);
    endtask

    initial begin
        tests = 0; fails = 0; mon_on = 0; pend = 0; max_seen = 0;
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        exp_digit = 4'd7; number_i = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_on = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("reset_idle",
                  {strobe_mask(), s_ready, busy, done, result, in_o, ld_neuron_o}, 64'h0);
        end

        exp_digit = 4'd7;
        run_job(1'b0, -1, -1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("result_hold", {busy, done, result}, {2'b00, 4'd7});
        end

        exp_digit = 4'($urandom_range(0, 15));
        run_job(1'b1, -1, -1);

        exp_digit = 4'($urandom_range(0, 15));
        run_job(1'b1, N_IN + 3 * (N_IN + 2) + 2 + 5, -1);

        exp_digit = 4'($urandom_range(0, 15));
        run_job(1'b0, -1, N_IN + 5 * (N_IN + 2) + 2 + 3);

        exp_digit = 4'($urandom_range(0, 15));
        run_job(1'b1, -1, -1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
